hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage core. It keeps a shadow scoreboard of in-flight destination registers and their remaining result latency (Tnew) for the E, M and W stages. From that scoreboard and the decode-stage operand use times (Tuse) it produces the fetch/decode stall enables, the bubble-insert clear for the D/E pipeline register, and the forwarding selects for the D, E and M stages. Optionally it also tracks a multi-cycle HI/LO mult/div unit.

---
 rtl/hazard_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage core.
// Keeps a shadow E/M/W scoreboard of destination registers and remaining
// result latency, and produces stall, bubble and forwarding controls.
// Optional HI/LO mult/div busy tracking is compiled in with HAZARD_MD_EN.
module hazard_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [1:0] tuse_rs_d,
    input  logic [1:0] tuse_rt_d,
    input  logic [4:0] wr_d,
    input  logic       regwrite_d,
    input  logic [1:0] tnew_d,
    input  logic       md_start_d,
    input  logic       md_div_d,
    input  logic       md_use_d,
    output logic       stall_f,
    output logic       stall_d,
    output logic       clr_d,
    output logic [1:0] fwd_rs_d,
    output logic [1:0] fwd_rt_d,
    output logic [1:0] fwd_rs_e,
    output logic [1:0] fwd_rt_e,
    output logic       fwd_rt_m
);

    localparam int unsigned REG_W  = 5;
    localparam int unsigned TNEW_W = 2;
    localparam int unsigned CNT_W  = 4;

    // Shadow pipeline state
    logic [REG_W-1:0]  rs_e_q, rs_e_d;
    logic [REG_W-1:0]  rt_e_q, rt_e_d;
    logic [REG_W-1:0]  wr_e_q, wr_e_d;
    logic              we_e_q, we_e_d;
    logic [TNEW_W-1:0] tnew_e_q, tnew_e_d;
    logic [REG_W-1:0]  rt_m_q, rt_m_d;
    logic [REG_W-1:0]  wr_m_q, wr_m_d;
    logic              we_m_q, we_m_d;
    logic [TNEW_W-1:0] tnew_m_q, tnew_m_d;
    logic [REG_W-1:0]  wr_w_q, wr_w_d;
    logic              we_w_q, we_w_d;

    logic stall_data;
    logic stall_md;
    logic stall;

    // Saturating one-step decrement of a result latency
    function automatic logic [TNEW_W-1:0] age(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : TNEW_W'(t - TNEW_W'(1));
    endfunction

    // Source s needs a result that a producer in E or M cannot deliver in time
    function automatic logic src_hazard(
        input logic [REG_W-1:0]  s,
        input logic [TNEW_W-1:0] tuse,
        input logic              we_e,
        input logic [REG_W-1:0]  wr_e,
        input logic [TNEW_W-1:0] tnew_e,
        input logic              we_m,
        input logic [REG_W-1:0]  wr_m,
        input logic [TNEW_W-1:0] tnew_m
    );
        logic h;
        h = 1'b0;
        if (tuse != 2'd3 && s != '0) begin
            if (we_e && wr_e == s && tnew_e > tuse) h = 1'b1;
            if (we_m && wr_m == s && tnew_m > tuse) h = 1'b1;
        end
        return h;
    endfunction

    // Forward select: 2 = M (result ready), 1 = W, 0 = none
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0]  s,
        input logic              we_m,
        input logic [REG_W-1:0]  wr_m,
        input logic [TNEW_W-1:0] tnew_m,
        input logic              we_w,
        input logic [REG_W-1:0]  wr_w
    );
        logic [1:0] f;
        f = 2'd0;
        if (we_m && wr_m == s && wr_m != '0 && tnew_m == '0) f = 2'd2;
        else if (we_w && wr_w == s && wr_w != '0)            f = 2'd1;
        return f;
    endfunction

    // Data hazard detection for both decode operands
    always_comb begin
        stall_data = 1'b0;
        if (src_hazard(rs_d, tuse_rs_d, we_e_q, wr_e_q, tnew_e_q, we_m_q, wr_m_q, tnew_m_q))
            stall_data = 1'b1;
        if (src_hazard(rt_d, tuse_rt_d, we_e_q, wr_e_q, tnew_e_q, we_m_q, wr_m_q, tnew_m_q))
            stall_data = 1'b1;
    end

    assign stall = stall_data | stall_md;

`ifdef HAZARD_MD_EN
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

    // Busy counter: loads on an issued mult/div, otherwise counts down to 0
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (!stall && md_start_d)
            md_cnt_d = md_div_d ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        else if (md_cnt_q != '0)
            md_cnt_d = CNT_W'(md_cnt_q - CNT_W'(1));
    end

    // Busy counter register
    always_ff @(posedge clk) begin
        if (reset) md_cnt_q <= '0;
        else       md_cnt_q <= md_cnt_d;
    end

    assign stall_md = md_use_d && (md_cnt_q != '0);
`else
    logic unused_md;
    assign unused_md = ^{md_start_d, md_div_d, md_use_d,
                         CNT_W'(MULT_CYCLES), CNT_W'(DIV_CYCLES)};
    assign stall_md  = 1'b0;
`endif

    // Shadow advance: E takes D (or a bubble on stall), M and W follow
    always_comb begin
        rs_e_d   = '0;
        rt_e_d   = '0;
        wr_e_d   = '0;
        we_e_d   = 1'b0;
        tnew_e_d = '0;
        if (!stall) begin
            rs_e_d   = rs_d;
            rt_e_d   = rt_d;
            wr_e_d   = wr_d;
            we_e_d   = regwrite_d && (wr_d != '0);
            tnew_e_d = age(tnew_d);
        end
        rt_m_d   = rt_e_q;
        wr_m_d   = wr_e_q;
        we_m_d   = we_e_q && (wr_e_q != '0);
        tnew_m_d = age(tnew_e_q);
        wr_w_d   = wr_m_q;
        we_w_d   = we_m_q && (wr_m_q != '0);
    end

    // Shadow registers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            rs_e_q   <= '0;
            rt_e_q   <= '0;
            wr_e_q   <= '0;
            we_e_q   <= 1'b0;
            tnew_e_q <= '0;
            rt_m_q   <= '0;
            wr_m_q   <= '0;
            we_m_q   <= 1'b0;
            tnew_m_q <= '0;
            wr_w_q   <= '0;
            we_w_q   <= 1'b0;
        end else begin
            rs_e_q   <= rs_e_d;
            rt_e_q   <= rt_e_d;
            wr_e_q   <= wr_e_d;
            we_e_q   <= we_e_d;
            tnew_e_q <= tnew_e_d;
            rt_m_q   <= rt_m_d;
            wr_m_q   <= wr_m_d;
            we_m_q   <= we_m_d;
            tnew_m_q <= tnew_m_d;
            wr_w_q   <= wr_w_d;
            we_w_q   <= we_w_d;
        end
    end

    // Zero-latency outputs, forced low while reset is held
    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        clr_d    = 1'b0;
        fwd_rs_d = 2'd0;
        fwd_rt_d = 2'd0;
        fwd_rs_e = 2'd0;
        fwd_rt_e = 2'd0;
        fwd_rt_m = 1'b0;
        if (!reset) begin
            stall_f  = stall;
            stall_d  = stall;
            clr_d    = stall;
            fwd_rs_d = fwd_sel(rs_d,   we_m_q, wr_m_q, tnew_m_q, we_w_q, wr_w_q);
            fwd_rt_d = fwd_sel(rt_d,   we_m_q, wr_m_q, tnew_m_q, we_w_q, wr_w_q);
            fwd_rs_e = fwd_sel(rs_e_q, we_m_q, wr_m_q, tnew_m_q, we_w_q, wr_w_q);
            fwd_rt_e = fwd_sel(rt_e_q, we_m_q, wr_m_q, tnew_m_q, we_w_q, wr_w_q);
            fwd_rt_m = we_w_q && (wr_w_q == rt_m_q) && (wr_w_q != '0);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios plus random traffic checked
// against an issue-history reference model (instruction age and remaining latency).
module tb_hazard_ctrl;

    localparam int N = 4096;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] rs_d = '0, rt_d = '0, wr_d = '0;
    logic [1:0] tuse_rs_d = 2'd3, tuse_rt_d = 2'd3, tnew_d = '0;
    logic       regwrite_d = 1'b0, md_start_d = 1'b0, md_div_d = 1'b0, md_use_d = 1'b0;
    logic       stall_f, stall_d, clr_d, fwd_rt_m;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

    always #5 clk = ~clk;

    hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset),
        .rs_d(rs_d), .rt_d(rt_d), .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
        .wr_d(wr_d), .regwrite_d(regwrite_d), .tnew_d(tnew_d),
        .md_start_d(md_start_d), .md_div_d(md_div_d), .md_use_d(md_use_d),
        .stall_f(stall_f), .stall_d(stall_d), .clr_d(clr_d),
        .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
        .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m)
    );

    int n_chk = 0, n_fail = 0;
    int cyc = 0, rst_cyc = 0, md_cyc = -1000, md_len = 0;

    // Issue history: what left decode at the end of each cycle (bubble on stall)
    bit [4:0] h_rs[N], h_rt[N], h_wr[N];
    bit       h_we[N];
    bit [1:0] h_tn[N];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Instruction issued a cycles ago is part of the current pipeline
    function automatic bit valid(int a);
        return (cyc - a >= 0) && (cyc - a > rst_cyc);
    endfunction

    function automatic bit live(int a);
        return valid(a) && h_we[cyc-a];
    endfunction

    // Remaining cycles until the result of an instruction of age a exists
    function automatic int rem(int a);
        int r;
        r = int'(h_tn[cyc-a]) - a;
        return (r < 0) ? 0 : r;
    endfunction

    function automatic bit src_stall(logic [4:0] s, logic [1:0] tuse);
        if (tuse == 2'd3 || s == 0) return 1'b0;
        for (int a = 1; a <= 2; a++)
            if (live(a) && h_wr[cyc-a] == s && rem(a) > int'(tuse)) return 1'b1;
        return 1'b0;
    endfunction

    // Age 2 is in M, age 3 is in W
    function automatic logic [1:0] fwd(logic [4:0] s);
        if (s != 0 && live(2) && h_wr[cyc-2] == s && rem(2) == 0) return 2'd2;
        if (s != 0 && live(3) && h_wr[cyc-3] == s) return 2'd1;
        return 2'd0;
    endfunction

    function automatic bit md_busy();
        return (md_cyc > rst_cyc) && (cyc - md_cyc <= md_len);
    endfunction

    // One cycle: drive D inputs, check all outputs against the model, then record
    task automatic step(input bit rst, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [1:0] tus, input logic [1:0] tut,
                        input logic [4:0] wr, input bit we, input logic [1:0] tn,
                        input bit mds, input bit mdd, input bit mdu);
        bit st;
        logic [4:0] rse, rte;
        @(negedge clk);
        reset = rst; rs_d = rs; rt_d = rt; tuse_rs_d = tus; tuse_rt_d = tut;
        wr_d = wr; regwrite_d = we; tnew_d = tn;
        md_start_d = mds; md_div_d = mdd; md_use_d = mdu;
        #1;
        st = src_stall(rs, tus) || src_stall(rt, tut);
`ifdef HAZARD_MD_EN
        if (mdu && md_busy()) st = 1'b1;
`endif
        rse = valid(1) ? h_rs[cyc-1] : 5'd0;
        rte = valid(2) ? h_rt[cyc-2] : 5'd0;
        if (rst) begin
            chk("stall_f", {7'd0, stall_f}, 8'd0);
            chk("stall_d", {7'd0, stall_d}, 8'd0);
            chk("clr_d", {7'd0, clr_d}, 8'd0);
            chk("fwd_rs_d", {6'd0, fwd_rs_d}, 8'd0);
            chk("fwd_rt_d", {6'd0, fwd_rt_d}, 8'd0);
            chk("fwd_rs_e", {6'd0, fwd_rs_e}, 8'd0);
            chk("fwd_rt_e", {6'd0, fwd_rt_e}, 8'd0);
            chk("fwd_rt_m", {7'd0, fwd_rt_m}, 8'd0);
            rst_cyc = cyc;
        end else begin
            chk("stall_f", {7'd0, stall_f}, {7'd0, st});
            chk("stall_d", {7'd0, stall_d}, {7'd0, st});
            chk("clr_d", {7'd0, clr_d}, {7'd0, st});
            chk("fwd_rs_d", {6'd0, fwd_rs_d}, {6'd0, fwd(rs)});
            chk("fwd_rt_d", {6'd0, fwd_rt_d}, {6'd0, fwd(rt)});
            chk("fwd_rs_e", {6'd0, fwd_rs_e}, {6'd0, fwd(rse)});
            chk("fwd_rt_e", {6'd0, fwd_rt_e},
                {6'd0, fwd(valid(1) ? h_rt[cyc-1] : 5'd0)});
            chk("fwd_rt_m", {7'd0, fwd_rt_m},
                {7'd0, (rte != 0 && live(3) && h_wr[cyc-3] == rte)});
            if (st) begin
                h_rs[cyc] = 0; h_rt[cyc] = 0; h_wr[cyc] = 0; h_we[cyc] = 0; h_tn[cyc] = 0;
            end else begin
                h_rs[cyc] = rs; h_rt[cyc] = rt; h_wr[cyc] = wr;
                h_we[cyc] = we && (wr != 0); h_tn[cyc] = tn;
                if (mds) begin md_cyc = cyc; md_len = mdd ? 10 : 5; end
            end
        end
        cyc++;
    endtask

    task automatic nop();
        step(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int cnt;
        // Reset held two cycles with a live-looking consumer
        step(1, 5, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        step(1, 5, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        step(0, 5, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        chk("post_reset_stall", {7'd0, stall_f}, 8'd0);
        chk("post_reset_fwd", {6'd0, fwd_rs_d}, 8'd0);

        // lw $8 then add rs=8 (tuse 1): exactly one stall cycle, then W forward in E
        step(0, 0, 0, 3, 3, 8, 1, 3, 0, 0, 0);
        step(0, 8, 0, 1, 3, 10, 1, 1, 0, 0, 0);
        chk("lw_add_stall1", {7'd0, stall_f}, 8'd1);
        step(0, 8, 0, 1, 3, 10, 1, 1, 0, 0, 0);
        chk("lw_add_stall2", {7'd0, stall_d}, 8'd0);
        nop();
        chk("lw_add_fwd_e", {6'd0, fwd_rs_e}, 8'd1);

        // addu $9 then beq rs=9 once addu is in M with tnew 0
        step(0, 0, 0, 3, 3, 9, 1, 1, 0, 0, 0);
        nop();
        step(0, 9, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        chk("addu_beq_stall", {7'd0, clr_d}, 8'd0);
        chk("addu_beq_fwd_d", {6'd0, fwd_rs_d}, 8'd2);

        // Writers of $0 are never hazards or forward sources
        step(0, 0, 0, 3, 3, 0, 1, 3, 0, 0, 0);
        step(0, 0, 0, 3, 3, 0, 1, 3, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("r0_stall", {7'd0, stall_f}, 8'd0);
        chk("r0_fwd_rs_d", {6'd0, fwd_rs_d}, 8'd0);
        nop();
        chk("r0_fwd_rs_e", {6'd0, fwd_rs_e}, 8'd0);
        chk("r0_fwd_rt_m", {7'd0, fwd_rt_m}, 8'd0);

        // $4 in both M (tnew 0) and W: M wins
        step(0, 0, 0, 3, 3, 4, 1, 1, 0, 0, 0);
        step(0, 0, 0, 3, 3, 4, 1, 1, 0, 0, 0);
        step(0, 4, 0, 3, 3, 0, 0, 0, 0, 0, 0);
        nop();
        chk("m_priority_fwd_e", {6'd0, fwd_rs_e}, 8'd2);

        // Reset mid-stall leaves no residual stall
        step(0, 0, 0, 3, 3, 8, 1, 3, 0, 0, 0);
        step(0, 8, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        chk("pre_reset_stall", {7'd0, stall_f}, 8'd1);
        step(1, 8, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        step(0, 8, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        chk("reset_mid_stall", {7'd0, stall_f}, 8'd0);

        // mult/div followed by mflo
        step(0, 0, 0, 3, 3, 0, 0, 0, 1, 0, 1);
`ifdef HAZARD_MD_EN
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 3, 3, 2, 1, 1, 0, 0, 1);
            if (stall_f !== 1'b1) break;
            cnt++;
        end
        chk("mult_stall_cycles", 8'(cnt), 8'd5);
        step(0, 0, 0, 3, 3, 0, 0, 0, 1, 1, 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 3, 3, 2, 1, 1, 0, 0, 1);
            if (stall_f !== 1'b1) break;
            cnt++;
        end
        chk("div_stall_cycles", 8'(cnt), 8'd10);
        step(0, 0, 0, 3, 3, 0, 0, 0, 1, 1, 1);
        step(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1);
        chk("div_busy_stall", {7'd0, stall_f}, 8'd1);
        step(1, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1);
        chk("reset_mid_busy", {7'd0, stall_f}, 8'd0);
`else
        cnt = 0;
        step(0, 0, 0, 3, 3, 2, 1, 1, 0, 0, 1);
        chk("md_disabled_stall", {7'd0, stall_f}, 8'd0);
`endif

        // Random traffic over a small register set to provoke hazards
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(63) == 0,
                 5'($urandom_range(3)), 5'($urandom_range(3)),
                 2'($urandom_range(3)), 2'($urandom_range(3)),
                 5'($urandom_range(3)), 1'($urandom_range(1)), 2'($urandom_range(3)),
                 $urandom_range(7) == 0, 1'($urandom_range(1)), $urandom_range(3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
